fp_normalize_round: RTL

Post-add normalization and rounding stage of the FP adder/subtractor. Consumes the raw sum mantissa, exponent, sign, guard/sticky bits and the normalization shift count produced by the zero-counting stage, and emits a packed IEEE-754 result with exception flags. The stage is a two-stage pipeline with valid/ready handshakes on both sides and sits between the zero counter and the FP register-file writeback mux.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_normalize_round_if.sv | 30 +++
 rtl/fp_round.sv | 47 ++++
 rtl/fp_normalize_round.sv | 113 +++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants and types for the FP adder normalize/round path.
package fp_pkg;

  localparam int SizeMantissa = 23;
  localparam int SizeExponent = 8;
  localparam int ExpBias      = 127;
  localparam int ExpMax       = (1 << SizeExponent) - 1;
  localparam int ExpWidth     = SizeExponent + 2;
  localparam int ShiftWidth   = $clog2(SizeMantissa + 1);

  localparam logic [ExpWidth-1:0] ExpMaxExt = ExpWidth'(ExpMax);

  typedef struct packed {
    logic                    sign;
    logic [SizeExponent-1:0] exponent;
    logic [SizeMantissa-1:0] fraction;
  } fp_result_t;

  // Normalized beat held between the two pipeline stages; exponent is two's complement.
  typedef struct packed {
    logic                    sign;
    logic [ExpWidth-1:0]     exponent;
    logic [SizeMantissa-1:0] fraction;
    logic                    guard;
    logic                    sticky;
    logic                    zero;
    logic                    flush;
  } norm_t;

  typedef enum logic [1:0] {
    NormPass,
    NormCarry,
    NormLeft,
    NormZero
  } norm_case_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Beat-in / result-out handshake bundle of the normalize/round stage.
interface fp_normalize_round_if;
  import fp_pkg::*;

  logic                      valid_i;
  logic                      ready_o;
  logic                      sign_i;
  logic [SizeExponent-1:0]   exponent_i;
  logic [SizeMantissa+1:0]   mantissa_i;
  logic                      guard_i;
  logic                      sticky_i;
  logic [ShiftWidth-1:0]     shift_i;
  logic                      valid_o;
  logic                      ready_i;
  fp_result_t                result_o;
  logic                      overflow_o;
  logic                      underflow_o;
  logic                      inexact_o;

  modport master (
    output valid_i, sign_i, exponent_i, mantissa_i, guard_i, sticky_i, shift_i, ready_i,
    input  ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
  );

  modport slave (
    input  valid_i, sign_i, exponent_i, mantissa_i, guard_i, sticky_i, shift_i, ready_i,
    output ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
  );

endinterface

// File: rtl/fp_round.sv
// Round-to-nearest-even on a normalized beat, with renormalization and overflow to infinity.
module fp_round
  import fp_pkg::*;
(
  input  norm_t      norm,
  output fp_result_t result,
  output logic       overflow,
  output logic       underflow,
  output logic       inexact
);

  logic                    round_up;
  logic                    carry;
  logic [SizeMantissa-1:0] fraction;
  logic [ExpWidth-1:0]     exponent;

  always_comb begin
    round_up = norm.guard & (norm.sticky | norm.fraction[0]);
    // Carry out of the fraction means the significand reached 2.0; fraction is already zero.
    {carry, fraction} = {1'b0, norm.fraction} + (SizeMantissa + 1)'(round_up);
    exponent = norm.exponent + ExpWidth'(carry);

    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = 1'b0;

    if (!norm.zero) begin
      if (norm.flush) begin
        result.sign = norm.sign;
        underflow   = 1'b1;
        inexact     = 1'b1;
      end else if (!exponent[ExpWidth-1] && (exponent >= ExpMaxExt)) begin
        result.sign     = norm.sign;
        result.exponent = '1;
        overflow        = 1'b1;
        inexact         = 1'b1;
      end else begin
        result.sign     = norm.sign;
        result.exponent = exponent[SizeExponent-1:0];
        result.fraction = fraction;
        inexact         = norm.guard | norm.sticky;
      end
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage post-add pipeline: normalize (stage 1) then RNE round and pack (stage 2).
module fp_normalize_round
  import fp_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  fp_normalize_round_if.slave bus
);

  logic                s1_valid;
  logic                s2_valid;
  logic                s1_load;
  logic                s2_load;
  norm_case_t          norm_case;
  logic [ExpWidth-1:0] exp_ext;
  norm_t               norm_d;
  norm_t               norm_q;
  fp_result_t          round_result;
  logic                round_ovf;
  logic                round_unf;
  logic                round_inx;
  fp_result_t          result_q;
  logic                ovf_q;
  logic                unf_q;
  logic                inx_q;

  assign bus.ready_o = ~s1_valid | ~s2_valid | bus.ready_i;
  assign s1_load     = bus.valid_i & bus.ready_o;
  assign s2_load     = s1_valid & (~s2_valid | bus.ready_i);

  always_comb begin
    exp_ext   = {2'b00, bus.exponent_i};
    norm_case = NormLeft;
    if ((bus.mantissa_i == '0) && !bus.guard_i && !bus.sticky_i) begin
      norm_case = NormZero;
    end else if (bus.mantissa_i[SizeMantissa+1]) begin
      norm_case = NormCarry;
    end else if (bus.shift_i == '0) begin
      norm_case = NormPass;
    end

    norm_d          = '0;
    norm_d.sign     = bus.sign_i;
    norm_d.exponent = exp_ext;
    norm_d.fraction = bus.mantissa_i[SizeMantissa-1:0];
    norm_d.guard    = bus.guard_i;
    norm_d.sticky   = bus.sticky_i;

    unique case (norm_case)
      NormCarry: begin
        norm_d.fraction = bus.mantissa_i[SizeMantissa:1];
        norm_d.exponent = exp_ext + ExpWidth'(1);
        norm_d.guard    = bus.mantissa_i[0];
        norm_d.sticky   = bus.guard_i | bus.sticky_i;
      end
      NormLeft: begin
        // Hidden bit is clear here, so the new hidden bit comes from the shifted fraction.
        norm_d.fraction = (bus.mantissa_i[SizeMantissa-1:0] << bus.shift_i)
                        | (SizeMantissa'(bus.guard_i) << (bus.shift_i - ShiftWidth'(1)));
        norm_d.exponent = exp_ext - ExpWidth'(bus.shift_i);
        norm_d.guard    = 1'b0;
        norm_d.sticky   = bus.sticky_i;
      end
      NormZero: begin
        norm_d.zero = 1'b1;
        norm_d.sign = 1'b0;
      end
      default: ;
    endcase

    norm_d.flush = !norm_d.zero
                 && (norm_d.exponent[ExpWidth-1] || (norm_d.exponent == '0));
  end

  fp_round u_round (
    .norm      (norm_q),
    .result    (round_result),
    .overflow  (round_ovf),
    .underflow (round_unf),
    .inexact   (round_inx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      norm_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      s2_valid <= s2_load | (s2_valid & ~bus.ready_i);
      if (s1_load) begin
        norm_q <= norm_d;
      end
      if (s2_load) begin
        result_q <= round_result;
        ovf_q    <= round_ovf;
        unf_q    <= round_unf;
        inx_q    <= round_inx;
      end
    end
  end

  assign bus.valid_o     = s2_valid;
  assign bus.result_o    = result_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.inexact_o   = inx_q;

endmodule
